// File: rtl/dense_pkg.sv
// Shared types and arithmetic helpers for the dense layer.
// Helpers take explicit widths so every lane size can reuse them.
package dense_pkg;

  localparam logic [1:0] ACT_ID    = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_HTANH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_FIN,
    ST_DONE
  } state_t;

  // Clamp a wide signed value into a dw-bit signed range.
  function automatic logic signed [31:0] sat_to_w(
    input logic signed [63:0] v,
    input int dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    return r[31:0];
  endfunction

  function automatic logic signed [31:0] act_apply(
    input logic [1:0] mode,
    input logic signed [31:0] v,
    input int fw
  );
    logic signed [31:0] one;
    logic signed [31:0] r;
    one = 32'sd1 <<< fw;
    r = v;
    case (mode)
      ACT_RELU: begin
        if (v < 0) r = '0;
      end
      ACT_HTANH: begin
        if (v > one) r = one;
        else if (v < -one) r = -one;
      end
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Parameter-load stream and req/ack inference handshake.
// Master drives words and requests; slave returns results.
interface dense_layer_seq_if #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2
);
  logic                      fill;
  logic [DATA_W-1:0]         val;
  logic                      loaded;
  logic                      req;
  logic [1:0]                act_mode;
  logic [N_IN*DATA_W-1:0]    x_in;
  logic                      ack;
  logic [N_OUT*DATA_W-1:0]   y_out;
  logic                      busy;

  modport master (
    output fill, val, req, act_mode, x_in,
    input  loaded, ack, y_out, busy
  );

  modport slave (
    input  fill, val, req, act_mode, x_in,
    output loaded, ack, y_out, busy
  );
endinterface

// File: rtl/dense_mac_lane.sv
// One neuron: scaled MAC accumulator, bias, saturation, activation.
// Result register holds its value until the next finish pulse.
module dense_mac_lane
  import dense_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int N_IN   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_fin,
  input  logic [1:0]               i_mode,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0]        o_y
);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + $clog2(N_IN) + 1;

  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_W-1:0]       r_y;
  logic signed [PW-1:0]    w_we;
  logic signed [PW-1:0]    w_xe;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_term;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [31:0]      w_sat;
  logic signed [31:0]      w_act;

  assign w_we   = PW'(i_w);
  assign w_xe   = PW'(i_x);
  assign w_prod = w_we * w_xe;
  // Arithmetic shift: rounds each product toward -inf.
  assign w_term = w_prod >>> FRAC_W;
  assign w_sum  = r_acc + ACC_W'(i_b);
  assign w_sat  = sat_to_w(64'(w_sum), DATA_W);
  assign w_act  = act_apply(i_mode, w_sat, FRAC_W);

  generate
    if (DATA_W < 32) begin : g_unused
      logic w_unused_hi;
      assign w_unused_hi = ^w_act[31:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_y   <= '0;
    end else begin
      if (i_clr) r_acc <= '0;
      else if (i_en) r_acc <= r_acc + ACC_W'(w_term);
      if (i_fin) r_y <= w_act[DATA_W-1:0];
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/dense_layer_seq.sv
// Fully-connected layer: serial parameter fill, parallel lanes,
// one input element per cycle, four-phase req/ack result handoff.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2
) (
  input logic             clk,
  input logic             rst,
  dense_layer_seq_if.slave bus
);
  localparam int NW = N_OUT * (N_IN + 1);
  localparam int IW = $clog2(NW);
  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_idx;
  logic              r_loaded;
  logic [KW-1:0]     r_k;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_w [N_OUT][N_IN];
  logic [DATA_W-1:0] r_b [N_OUT];
  logic [DATA_W-1:0] r_x [N_IN];

  logic w_wr;
  logic w_start;
  logic w_mac;
  logic w_fin;
  logic w_klast;
  logic w_ilast;
  logic [N_OUT*DATA_W-1:0] w_y;

  assign w_wr    = bus.fill && (r_state == ST_IDLE);
  assign w_klast = (r_k == KW'(N_IN - 1));
  assign w_ilast = (r_idx == IW'(NW - 1));
  assign w_mac   = (r_state == ST_MAC);
  assign w_fin   = (r_state == ST_FIN);

  // Fill wins over req in IDLE.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!bus.fill && bus.req && r_loaded) begin
          w_next  = ST_MAC;
          w_start = 1'b1;
        end
      end
      ST_MAC:  if (w_klast) w_next = ST_FIN;
      ST_FIN:  w_next = ST_DONE;
      ST_DONE: if (!bus.req) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_loaded <= 1'b0;
      r_k      <= '0;
      r_mode   <= ACT_ID;
      for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr) begin
        r_loaded <= w_ilast;
        r_idx    <= w_ilast ? '0 : r_idx + IW'(1);
      end
      if (w_start) begin
        r_k    <= '0;
        r_mode <= bus.act_mode;
        for (int i = 0; i < N_IN; i++)
          r_x[i] <= bus.x_in[i*DATA_W +: DATA_W];
      end else if (w_mac) begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  // Parameter storage survives reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      for (int n = 0; n < N_OUT; n++) begin
        for (int i = 0; i < N_IN; i++)
          if (r_idx == IW'(n * N_IN + i)) r_w[n][i] <= bus.val;
        if (r_idx == IW'(N_OUT * N_IN + n)) r_b[n] <= bus.val;
      end
    end
  end

  generate
    for (genvar n = 0; n < N_OUT; n++) begin : g_lane
      dense_mac_lane #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_IN   (N_IN)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (w_mac),
        .i_fin  (w_fin),
        .i_mode (r_mode),
        .i_w    (r_w[n][r_k]),
        .i_x    (r_x[r_k]),
        .i_b    (r_b[n]),
        .o_y    (w_y[n*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign bus.y_out  = w_y;
  assign bus.ack    = (r_state == ST_DONE);
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.loaded = r_loaded;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq (8-bit Q4.4, 2 inputs, 2 neurons).
// Expected results are hand-computed fixed-point constants.
module tb_dense_layer_seq;
  localparam int N_IN = 2;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  dense_layer_seq_if #(.DATA_W(8), .N_IN(2), .N_OUT(2)) bus ();

  dense_layer_seq #(
    .DATA_W (8),
    .FRAC_W (4),
    .N_IN   (2),
    .N_OUT  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] v);
    bus.fill = 1'b1;
    bus.val  = v;
    step();
    bus.fill = 1'b0;
  endtask

  task automatic load(input string tag,
                      input logic [7:0] w00, input logic [7:0] w01,
                      input logic [7:0] w10, input logic [7:0] w11,
                      input logic [7:0] b0, input logic [7:0] b1);
    put(w00); put(w01); put(w10); put(w11); put(b0);
    chk({tag, ".loaded5"}, 32'(bus.loaded), 32'd0);
    put(b1);
    chk({tag, ".loaded6"}, 32'(bus.loaded), 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] x0,
                     input logic [7:0] x1, input logic [1:0] m,
                     input logic [15:0] exp, input bit mac_fill);
    bus.x_in     = {x1, x0};
    bus.act_mode = m;
    bus.req      = 1'b1;
    step();
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    bus.x_in     = ~{x1, x0};
    bus.act_mode = ~m;
    if (mac_fill) begin
      bus.fill = 1'b1;
      bus.val  = 8'h55;
    end
    repeat (N_IN) begin
      step();
      bus.fill = 1'b0;
    end
    chk({tag, ".ack_early"}, 32'(bus.ack), 32'd0);
    step();
    chk({tag, ".ack"}, 32'(bus.ack), 32'd1);
    chk({tag, ".y"}, 32'(bus.y_out), 32'(exp));
    step();
    chk({tag, ".ack_hold"}, 32'(bus.ack), 32'd1);
    bus.req = 1'b0;
    step();
    chk({tag, ".ack_drop"}, 32'(bus.ack), 32'd0);
    chk({tag, ".y_keep"}, 32'(bus.y_out), 32'(exp));
    step();
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    bus.fill     = 1'b0;
    bus.val      = '0;
    bus.req      = 1'b0;
    bus.act_mode = 2'd0;
    bus.x_in     = '0;
    step();
    step();
    chk("rst.ack", 32'(bus.ack), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.y", 32'(bus.y_out), 32'd0);
    chk("rst.loaded", 32'(bus.loaded), 32'd0);
    rst = 1'b0;

    // req before any parameters are loaded
    bus.x_in = 16'h2010;
    bus.req  = 1'b1;
    step();
    chk("noload.busy", 32'(bus.busy), 32'd0);
    step();
    chk("noload.ack", 32'(bus.ack), 32'd0);
    bus.req = 1'b0;

    load("s1", 8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'h08);

    // 7th word with req high: fill wins, loaded drops, lands in w[0][0]
    bus.req = 1'b1;
    put(8'h20);
    chk("fillreq.busy", 32'(bus.busy), 32'd0);
    chk("seventh.loaded", 32'(bus.loaded), 32'd0);
    step();
    chk("unloaded.req.busy", 32'(bus.busy), 32'd0);
    bus.req = 1'b0;
    put(8'h10); put(8'h10); put(8'h10); put(8'h08);
    chk("refill4.loaded", 32'(bus.loaded), 32'd0);
    put(8'h08);
    chk("refill5.loaded", 32'(bus.loaded), 32'd1);
    run("w00", 8'h10, 8'h20, 2'd0, 16'h3848, 1'b0);

    load("s1b", 8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'h08);
    run("s1", 8'h10, 8'h20, 2'd0, 16'h3838, 1'b1);
    chk("macfill.loaded", 32'(bus.loaded), 32'd1);
    run("htanh_pos", 8'h10, 8'h20, 2'd2, 16'h1010, 1'b0);

    load("s2", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00);
    run("s2.id", 8'h10, 8'h20, 2'd0, 16'hD0D0, 1'b0);
    run("s2.relu", 8'h10, 8'h20, 2'd1, 16'h0000, 1'b0);
    run("s2.htanh", 8'h10, 8'h20, 2'd2, 16'hF0F0, 1'b0);
    run("s2.mode3", 8'h10, 8'h20, 2'd3, 16'hD0D0, 1'b0);

    load("satp", 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run("satp", 8'h7F, 8'h7F, 2'd0, 16'h7F7F, 1'b0);
    load("satn", 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    run("satn", 8'h7F, 8'h7F, 2'd0, 16'h8080, 1'b0);

    // -1/16 * 1/16 floors to -1 lsb per term
    load("trunc", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
    run("trunc", 8'h01, 8'h01, 2'd0, 16'hFEFE, 1'b0);

    // abort in the second MAC cycle
    load("abort", 8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'h08);
    bus.x_in     = 16'h2010;
    bus.act_mode = 2'd0;
    bus.req      = 1'b1;
    step();
    step();
    chk("abort.inmac", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    chk("abort.ack", 32'(bus.ack), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.y", 32'(bus.y_out), 32'd0);
    chk("abort.loaded", 32'(bus.loaded), 32'd0);
    rst     = 1'b0;
    bus.req = 1'b0;
    step();
    load("reload", 8'h10, 8'h10, 8'h10, 8'h10, 8'h08, 8'h08);
    run("rerun", 8'h10, 8'h20, 2'd0, 16'h3838, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
